// File: rtl/srsw_arb_pkg.sv
// srsw_arb_pkg: shared widths and helpers for the shared-RAM port arbiter
package srsw_arb_pkg;
    localparam int MAX_AW = 16;
    localparam int MAX_BUS = 8 * MAX_AW;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // single-requester sides still need a 1-bit (constant zero) pointer
    function automatic int ptr_w(input int n);
        return n > 1 ? clog2(n) : 1;
    endfunction

    function automatic logic [MAX_AW-1:0] slice_addr(input logic [MAX_BUS-1:0] bus, input int idx, input int aw);
        logic [MAX_BUS-1:0] s;
        s = bus >> (idx * aw);
        return s[MAX_AW-1:0];
    endfunction
endpackage

// File: rtl/srsw_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, wrapping modulo N
module rr_arbiter import srsw_arb_pkg::*; #(
    parameter int N = 2,
    localparam int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          any
);
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        grant_idx = '0;
        // scan from farthest to nearest so the requester closest to ptr wins
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (1'(req >> j)) begin
                grant = N'(1) << j;
                grant_idx = PW'(j);
            end
        end
    end

    assign any = |req;
endmodule

// File: rtl/srsw_port_arbiter.sv
// srsw_port_arbiter: round-robin sharing of one 1W/1R RAM among NWR writers and NRD readers
module srsw_port_arbiter import srsw_arb_pkg::*; #(
    parameter int NRD = 2,
    parameter int NWR = 2,
    parameter int AW  = 2,
    parameter int DW  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    wr_valid,
    output logic [NWR-1:0]    wr_ready,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic [NWR*DW-1:0] wr_data,
    input  logic [NRD-1:0]    rd_valid,
    output logic [NRD-1:0]    rd_ready,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rresp_valid,
    output logic [DW-1:0]     rresp_data,
    output logic              ram_wen,
    output logic [AW-1:0]     ram_waddr,
    output logic [DW-1:0]     ram_wdata,
    output logic              ram_ren,
    output logic [AW-1:0]     ram_raddr,
    input  logic [DW-1:0]     ram_rdata
);
    localparam int WPW = ptr_w(NWR);
    localparam int RPW = ptr_w(NRD);

    logic [WPW-1:0] wr_ptr, wr_idx;
    logic [RPW-1:0] rd_ptr, rd_idx;
    logic [NWR-1:0] wr_gnt;
    logic [NRD-1:0] rd_gnt, resp_sel;
    logic           wr_any, rd_any;
    logic [AW-1:0]  rd_cand_addr;

    rr_arbiter #(.N(NWR)) u_wr_arb (
        .req(wr_valid), .ptr(wr_ptr), .grant(wr_gnt), .grant_idx(wr_idx), .any(wr_any)
    );

    rr_arbiter #(.N(NRD)) u_rd_arb (
        .req(rd_valid), .ptr(rd_ptr), .grant(rd_gnt), .grant_idx(rd_idx), .any(rd_any)
    );

    always_comb begin
        ram_wen = rst_n && wr_any;
        ram_waddr = AW'(slice_addr(MAX_BUS'(wr_addr), int'(wr_idx), AW));
        ram_wdata = DW'(wr_data >> (int'(wr_idx) * DW));
        rd_cand_addr = AW'(slice_addr(MAX_BUS'(rd_addr), int'(rd_idx), AW));
        // a read colliding with this cycle's write waits one cycle to see the new data
        ram_ren = rst_n && rd_any && !(ram_wen && rd_cand_addr == ram_waddr);
        ram_raddr = rd_cand_addr;
        wr_ready = ram_wen ? wr_gnt : '0;
        rd_ready = ram_ren ? rd_gnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            resp_sel <= '0;
        end else begin
            if (ram_wen) wr_ptr <= (wr_idx == WPW'(NWR - 1)) ? '0 : wr_idx + 1'b1;
            if (ram_ren) rd_ptr <= (rd_idx == RPW'(NRD - 1)) ? '0 : rd_idx + 1'b1;
            resp_sel <= rd_ready;
        end
    end

    assign rresp_valid = resp_sel;
    assign rresp_data = ram_rdata;
endmodule

// File: tb/tb_srsw_port_arbiter.sv
// tb_srsw_port_arbiter: directed steps with a response scoreboard against a behavioural RAM
module tb_srsw_port_arbiter;
    localparam int NRD = 2, NWR = 2, AW = 2, DW = 32;

    logic              clk = 0;
    logic              rst_n;
    logic [NWR-1:0]    wr_valid, wr_ready;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic [NRD-1:0]    rd_valid, rd_ready, rresp_valid;
    logic [NRD*AW-1:0] rd_addr;
    logic [DW-1:0]     rresp_data, ram_wdata, ram_rdata;
    logic              ram_wen, ram_ren;
    logic [AW-1:0]     ram_waddr, ram_raddr;
    logic [DW-1:0]     mem [4];

    int checks = 0;
    int errors = 0;
    logic [NRD+DW-1:0] sb [$];

    srsw_port_arbiter #(.NRD(NRD), .NWR(NWR), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rresp_valid(rresp_valid), .rresp_data(rresp_data),
        .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_ren(ram_ren), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (ram_wen) mem[ram_waddr] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rresp_valid != '0) begin
            if (sb.size() == 0) chk("resp_unexpected", 64'(rresp_valid), 64'(0));
            else begin
                logic [NRD+DW-1:0] e;
                e = sb.pop_front();
                chk("resp_sel", 64'(rresp_valid), 64'(e[NRD+DW-1:DW]));
                chk("resp_data", 64'(rresp_data), 64'(e[DW-1:0]));
            end
        end
    end

    initial begin
        rst_n = 0;
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = 2'b11; rd_addr = '0;
        #3;
        chk("rst_wen", 64'(ram_wen), 64'(0));
        chk("rst_ren", 64'(ram_ren), 64'(0));
        chk("rst_rd_ready", 64'(rd_ready), 64'(0));
        chk("rst_wr_ready", 64'(wr_ready), 64'(0));
        chk("rst_rresp", 64'(rresp_valid), 64'(0));
        rd_valid = '0;
        @(negedge clk);
        rst_n = 1;
        repeat (10) begin
            tick();
            @(negedge clk);
            chk("idle_wen", 64'(ram_wen), 64'(0));
            chk("idle_ren", 64'(ram_ren), 64'(0));
            chk("idle_rresp", 64'(rresp_valid), 64'(0));
        end

        tick();
        wr_valid = 2'b01; wr_addr = {2'd0, 2'd1}; wr_data = {32'h0, 32'hDEADBEEF};
        @(negedge clk);
        chk("w0_ready", 64'(wr_ready), 64'(2'b01));
        chk("w0_waddr", 64'(ram_waddr), 64'(1));
        chk("w0_wdata", 64'(ram_wdata), 64'(32'hDEADBEEF));
        tick();
        wr_valid = '0; rd_valid = 2'b10; rd_addr = {2'd1, 2'd0};
        @(negedge clk);
        chk("r1_ready", 64'(rd_ready), 64'(2'b10));
        chk("r1_raddr", 64'(ram_raddr), 64'(1));
        sb.push_back({2'b10, 32'hDEADBEEF});

        tick();
        rd_valid = 2'b11; rd_addr = {2'd1, 2'd1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_rd", 64'(rd_ready), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
            sb.push_back({(i % 2 == 0) ? 2'b01 : 2'b10, 32'hDEADBEEF});
            tick();
        end
        rd_valid = '0;

        wr_valid = 2'b11; wr_addr = {2'd3, 2'd0}; wr_data = {32'h33333333, 32'hA0A0A0A0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_wr", 64'(wr_ready), (i % 2 == 0) ? 64'(2'b10) : 64'(2'b01));
            chk("rr_waddr", 64'(ram_waddr), (i % 2 == 0) ? 64'(3) : 64'(0));
            tick();
        end

        wr_valid = 2'b01; wr_addr = {2'd0, 2'd2}; wr_data = {32'h0, 32'h11111111};
        @(negedge clk);
        chk("prefill_ready", 64'(wr_ready), 64'(2'b01));
        tick();
        wr_valid = 2'b10; wr_addr = {2'd2, 2'd0}; wr_data = {32'h22222222, 32'h0};
        rd_valid = 2'b01; rd_addr = {2'd0, 2'd2};
        @(negedge clk);
        chk("conf_wr_ready", 64'(wr_ready), 64'(2'b10));
        chk("conf_rd_ready", 64'(rd_ready), 64'(0));
        chk("conf_ren", 64'(ram_ren), 64'(0));
        tick();
        wr_valid = '0;
        @(negedge clk);
        chk("conf_retry", 64'(rd_ready), 64'(2'b01));
        sb.push_back({2'b01, 32'h22222222});
        tick();
        wr_valid = 2'b01; wr_addr = {2'd0, 2'd0}; wr_data = {32'h0, 32'h0BADF00D};
        rd_valid = 2'b01; rd_addr = {2'd0, 2'd3};
        @(negedge clk);
        chk("ovl_wr_ready", 64'(wr_ready), 64'(2'b01));
        chk("ovl_rd_ready", 64'(rd_ready), 64'(2'b01));
        sb.push_back({2'b01, 32'h33333333});
        tick();
        wr_valid = '0;
        rd_valid = 2'b10; rd_addr = {2'd0, 2'd0};
        @(negedge clk);
        chk("pre_rst_grant", 64'(rd_ready), 64'(2'b10));
        #1 rst_n = 0;
        #1;
        chk("mid_rst_ready", 64'(rd_ready), 64'(0));
        chk("mid_rst_ren", 64'(ram_ren), 64'(0));
        tick();
        @(negedge clk);
        chk("mid_rst_rresp", 64'(rresp_valid), 64'(0));
        rd_valid = '0;
        rst_n = 1;
        tick();
        rd_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_grant", 64'(rd_ready), 64'(2'b01));
        sb.push_back({2'b01, 32'h0BADF00D});
        tick();
        rd_valid = '0;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
